// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-to-slave memory bus controller.
package mem_bus_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_N_SLV   = 4;
   localparam int DEF_TIMEOUT = 15;

   // Low address bits that must be zero for a word-aligned access
   localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_bus_decode.sv
// Slave index to one-hot select decoder; flags indices with no slave behind them.
module mem_bus_decode #(
   parameter int N_SLV = 4,
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0] idx,
   output logic [N_SLV-1:0] sel,
   output logic             unmapped
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < N_SLV; i++)
         sel[i] = (idx == SEL_W'(i));
   end

   assign unmapped = ~|sel;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-master bus controller: IDLE latches a CPU request, ACCESS waits on the
// selected slave, DONE returns the result. Define MEM_BUS_ERR_EN for error handling.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int N_SLV   = DEF_N_SLV,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_stall,
   output logic                    cpu_err,
   output logic [N_SLV-1:0]        slv_sel,
   output logic                    slv_we,
   output logic [ADDR_W-1:0]       slv_addr,
   output logic [DATA_W-1:0]       slv_wdata,
   input  logic [N_SLV*DATA_W-1:0] slv_rdata,
   input  logic [N_SLV-1:0]        slv_ready
);

   localparam int SEL_W = $clog2(N_SLV);
   localparam int WC_W  = $clog2(TIMEOUT + 1);

   state_t            state;
   logic [WC_W-1:0]   wait_cnt;
   logic              skip;
   logic [N_SLV-1:0]  dec_sel;
   logic              dec_unmapped;
   logic              bad;
   logic [DATA_W-1:0] rd_mux;

   mem_bus_decode #(.N_SLV(N_SLV), .SEL_W(SEL_W)) u_dec (
      .idx      (cpu_addr[ADDR_W-1 -: SEL_W]),
      .sel      (dec_sel),
      .unmapped (dec_unmapped)
   );

`ifdef MEM_BUS_ERR_EN
   assign bad = dec_unmapped | (|(cpu_addr[1:0] & MISALIGN_MASK));
`else
   assign bad = dec_unmapped;
   assign cpu_err = 1'b0;
`endif

   // slv_sel holds at most one bit, so OR-ing the selected lanes is a mux
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_SLV; i++)
         if (slv_sel[i]) rd_mux = rd_mux | slv_rdata[i*DATA_W +: DATA_W];
   end

   assign cpu_stall = cpu_req & (state != DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cpu_rdata <= '0;
         slv_sel   <= '0;
         slv_we    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         wait_cnt  <= '0;
         skip      <= 1'b0;
`ifdef MEM_BUS_ERR_EN
         cpu_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               slv_addr  <= cpu_addr;
               slv_we    <= cpu_we;
               slv_wdata <= cpu_wdata;
               slv_sel   <= bad ? '0 : dec_sel;
               skip      <= bad;
               wait_cnt  <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (skip) begin
                  state <= DONE;
`ifdef MEM_BUS_ERR_EN
                  cpu_err <= 1'b1;
`else
                  if (!slv_we) cpu_rdata <= '0;
`endif
               end else if (|(slv_sel & slv_ready)) begin
                  if (!slv_we) cpu_rdata <= rd_mux;
                  slv_sel <= '0;
                  state   <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`ifdef MEM_BUS_ERR_EN
                  if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                     slv_sel <= '0;
                     cpu_err <= 1'b1;
                     state   <= DONE;
                  end
`endif
               end
            end
            DONE: begin
               state <= IDLE;
`ifdef MEM_BUS_ERR_EN
               cpu_err <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (3 slaves, TIMEOUT 15); expectations follow MEM_BUS_ERR_EN.
module tb_mem_bus_ctrl;

   localparam int NS = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [31:0]   cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic [31:0]   cpu_rdata;
   logic          cpu_stall;
   logic          cpu_err;
   logic [NS-1:0] slv_sel;
   logic          slv_we;
   logic [31:0]   slv_addr;
   logic [31:0]   slv_wdata;
   logic [NS*32-1:0] slv_rdata;
   logic [NS-1:0] slv_ready;

   mem_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .N_SLV(NS), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall), .cpu_err(cpu_err), .slv_sel(slv_sel),
      .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
      .slv_rdata(slv_rdata), .slv_ready(slv_ready)
   );

   always #5 clk = ~clk;

   // Slave model: selected slave answers after dly cycles of select; noise drives other readies
   int          sel_cnt = 0;
   int          dly = 0;
   int          wr_cnt = 0;
   logic [NS-1:0] rdy_noise = '0;

   assign slv_rdata = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
   assign slv_ready = (slv_sel & {NS{sel_cnt >= dly}}) | rdy_noise;

   always @(posedge clk) begin
      sel_cnt <= (slv_sel == '0) ? 0 : sel_cnt + 1;
      if (slv_we && |(slv_sel & slv_ready)) wr_cnt <= wr_cnt + 1;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   logic        first_stall, bus_bad, err_early, tmo;
   int          acc_n, sel_n;
   logic [31:0] done_rdata;
   logic        done_err;
   logic [NS-1:0] done_sel;

   // One request: counts ACCESS cycles, watches the slave bus, samples outputs in DONE
   task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [NS-1:0] esel, input bit hold);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      #1 first_stall = cpu_stall;
      acc_n = 0; sel_n = 0; bus_bad = 0; err_early = 0; tmo = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!cpu_stall) break;
         acc_n++;
         if (cpu_err) err_early = 1;
         if (slv_sel != '0) begin
            sel_n++;
            if (slv_sel !== esel || slv_we !== we || slv_addr !== addr || slv_wdata !== wdata)
               bus_bad = 1;
         end
         // the in-flight access must ignore later CPU-side changes
         if (c == 0) begin cpu_addr = ~addr; cpu_we = ~we; cpu_wdata = ~wdata; end
      end
      tmo = cpu_stall;
      done_rdata = cpu_rdata; done_err = cpu_err; done_sel = slv_sel;
      if (!hold) cpu_req = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      int            dly;
      logic [NS-1:0] noise;
      logic [31:0]   exp_rdata;
      logic          exp_err;
      int            exp_acc;
      logic [NS-1:0] exp_sel;
   } vec_t;

   vec_t vt[7];

   initial begin
      int wr0;
      logic ok;

      vt[0] = '{1'b0, 32'h0000_0010, 32'h0,      0, 3'b000, 32'hDEAD_BEEF, 1'b0, 1, 3'b001};
      vt[1] = '{1'b1, 32'h8000_0004, 32'h1234,   4, 3'b000, 32'hDEAD_BEEF, 1'b0, 5, 3'b100};
      vt[2] = '{1'b0, 32'h4000_0008, 32'h0,      2, 3'b000, 32'h1111_1111, 1'b0, 3, 3'b010};
      vt[3] = '{1'b0, 32'h8000_0000, 32'h0,      1, 3'b011, 32'h2222_2222, 1'b0, 2, 3'b100};
`ifdef MEM_BUS_ERR_EN
      vt[4] = '{1'b0, 32'hC000_0000, 32'h0,      0, 3'b111, 32'h2222_2222, 1'b1, 1, 3'b000};
      vt[5] = '{1'b0, 32'h0000_0002, 32'h0,      0, 3'b000, 32'h2222_2222, 1'b1, 1, 3'b000};
      vt[6] = '{1'b1, 32'h4000_0000, 32'hA5A5,   0, 3'b000, 32'h2222_2222, 1'b0, 1, 3'b010};
`else
      vt[4] = '{1'b0, 32'hC000_0000, 32'h0,      0, 3'b111, 32'h0000_0000, 1'b0, 1, 3'b000};
      vt[5] = '{1'b0, 32'h0000_0002, 32'h0,      0, 3'b000, 32'hDEAD_BEEF, 1'b0, 1, 3'b001};
      vt[6] = '{1'b1, 32'h4000_0000, 32'hA5A5,   0, 3'b000, 32'hDEAD_BEEF, 1'b0, 1, 3'b010};
`endif

      // Reset state
      #2 reset = 1'b0;
      #1;
      chk("rst rdata", cpu_rdata, 32'h0);
      chk("rst err", 32'(cpu_err), 32'h0);
      chk("rst sel", 32'(slv_sel), 32'h0);
      chk("rst we", 32'(slv_we), 32'h0);
      chk("rst addr", slv_addr, 32'h0);
      chk("rst wdata", slv_wdata, 32'h0);
      chk("rst stall", 32'(cpu_stall), 32'h0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 7; i++) begin
         dly = vt[i].dly; rdy_noise = vt[i].noise;
         run(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_sel, 1'b0);
         chk($sformatf("v%0d stall_first", i), 32'(first_stall), 32'h1);
         chk($sformatf("v%0d timeout", i), 32'(tmo), 32'h0);
         chk($sformatf("v%0d access_cycles", i), acc_n, vt[i].exp_acc);
         chk($sformatf("v%0d sel_cycles", i), sel_n, (vt[i].exp_sel != '0) ? vt[i].exp_acc : 0);
         chk($sformatf("v%0d bus", i), 32'(bus_bad), 32'h0);
         chk($sformatf("v%0d err_early", i), 32'(err_early), 32'h0);
         chk($sformatf("v%0d rdata", i), done_rdata, vt[i].exp_rdata);
         chk($sformatf("v%0d err", i), 32'(done_err), 32'(vt[i].exp_err));
         chk($sformatf("v%0d done_sel", i), 32'(done_sel), 32'h0);
      end
      rdy_noise = '0;

      // Slave that never answers
`ifdef MEM_BUS_ERR_EN
      dly = 1000;
      run(1'b0, 32'h4000_0004, 32'h0, 3'b010, 1'b0);
      chk("tmo access_cycles", acc_n, 15);
      chk("tmo sel_cycles", sel_n, 15);
      chk("tmo err", 32'(done_err), 32'h1);
      chk("tmo rdata", done_rdata, 32'h2222_2222);
      chk("tmo done_sel", 32'(done_sel), 32'h0);
`else
      dly = 1000;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0004;
      ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!cpu_stall || slv_sel !== 3'b010 || cpu_err !== 1'b0) ok = 1'b0;
      end
      chk("nowait stall_held", 32'(ok), 32'h1);
      reset = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("nowait sel_cleared", 32'(slv_sel), 32'h0);
`endif

      // Back-to-back with req held through DONE
      dly = 2;
      run(1'b0, 32'h4000_0000, 32'h0, 3'b010, 1'b1);
      chk("b2b first acc", acc_n, 3);
      chk("b2b first rdata", done_rdata, 32'h1111_1111);
      dly = 0;
      run(1'b0, 32'h0000_0000, 32'h0, 3'b001, 1'b0);
      chk("b2b idle stall", 32'(first_stall), 32'h1);
      chk("b2b second acc", acc_n, 1);
      chk("b2b second bus", 32'(bus_bad), 32'h0);
      chk("b2b second rdata", done_rdata, 32'hDEAD_BEEF);

      // Reset in the middle of a write
      dly = 1000;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_0008; cpu_wdata = 32'h55AA;
      @(negedge clk); @(negedge clk);
      chk("mid sel", 32'(slv_sel), 32'h4);
      chk("mid we", 32'(slv_we), 32'h1);
      wr0 = wr_cnt;
      reset = 1'b0; cpu_req = 1'b0;
      #1;
      chk("mid rst sel", 32'(slv_sel), 32'h0);
      chk("mid rst we", 32'(slv_we), 32'h0);
      chk("mid rst addr", slv_addr, 32'h0);
      chk("mid rst wdata", slv_wdata, 32'h0);
      chk("mid rst rdata", cpu_rdata, 32'h0);
      chk("mid rst err", 32'(cpu_err), 32'h0);
      chk("mid rst stall", 32'(cpu_stall), 32'h0);
      dly = 0;
      @(negedge clk);
      chk("mid no write", wr_cnt, wr0);
      reset = 1'b1;
      run(1'b1, 32'h8000_0008, 32'h55AA, 3'b100, 1'b0);
      chk("reissue stall_first", 32'(first_stall), 32'h1);
      chk("reissue acc", acc_n, 1);
      chk("reissue bus", 32'(bus_bad), 32'h0);
      chk("reissue write", wr_cnt, wr0 + 1);
      chk("reissue rdata", done_rdata, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
